// File: rtl/rgb_sram_writer_pkg.sv
// -----------------------------------------------------------------------------
// rgb_sram_writer_pkg
// Shared definitions for the RGB SRAM writer and its pixel FIFO:
//   - wr_state_e      : writer FSM state encoding
//   - rgb_pixel_t     : one 24-bit pixel {R, G, B}
//   - RGB_BASE_ADDR_DEF, FRAME_PIXELS : default frame placement and size
//   - pack_word()     : selects one of the three 16-bit words of a pixel pair
// -----------------------------------------------------------------------------
package rgb_sram_writer_pkg;

  localparam int unsigned RGB_BASE_ADDR_DEF = 146944;
  localparam int unsigned FRAME_PIXELS      = 76800;
  localparam int unsigned FIFO_DEPTH        = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_WR0  = 3'd2,
    S_WR1  = 3'd3,
    S_WR2  = 3'd4,
    S_DONE = 3'd5
  } wr_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_pixel_t;

  // A pixel pair (P0, P1) occupies three SRAM words:
  //   idx 0 : {R0, G0}   idx 1 : {B0, R1}   idx 2 : {G1, B1}
  function automatic logic [15:0] pack_word(input rgb_pixel_t p0,
                                            input rgb_pixel_t p1,
                                            input logic [1:0] idx);
    logic [15:0] w;
    case (idx)
      2'd0:    w = {p0.r, p0.g};
      2'd1:    w = {p0.b, p1.r};
      default: w = {p1.g, p1.b};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rgb_sram_writer_fifo.sv
// -----------------------------------------------------------------------------
// rgb_pixel_fifo
// 4-deep, 24-bit pixel FIFO between the upstream colour converter and the
// SRAM writer. Pops are always a whole pixel pair: the two oldest entries are
// presented on head0_o/head1_o and pop_i removes both at once.
//
// Ports:
//   clk_i    in   clock
//   rst_i    in   synchronous active-high reset (empties the FIFO)
//   push_i   in   write data_i into the tail
//   pop_i    in   remove the two oldest entries (ignored with fewer than 2)
//   data_i   in   24-bit pixel
//   head0_o  out  oldest entry
//   head1_o  out  second-oldest entry
//   count_o  out  occupancy 0..4
//   empty_o  out  occupancy == 0
//   full_o   out  occupancy == 4
// -----------------------------------------------------------------------------
module rgb_pixel_fifo
  import rgb_sram_writer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [23:0] data_i,
  output logic [23:0] head0_o,
  output logic [23:0] head1_o,
  output logic [2:0]  count_o,
  output logic        empty_o,
  output logic        full_o
);

  logic [23:0] mem_q [FIFO_DEPTH];
  logic [1:0]  wr_ptr_q;
  logic [1:0]  rd_ptr_q;
  logic [2:0]  count_q;
  logic        push_ok;
  logic        pop_ok;

  assign pop_ok  = pop_i && (count_q >= 3'd2);
  // A push into a full FIFO is safe when a pop happens the same cycle: the
  // slot being overwritten is the old head, which is consumed this cycle.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 2'd2;
      count_q <= 3'(count_q + {2'b00, push_ok} - {1'b0, pop_ok, 1'b0});
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign head0_o = mem_q[rd_ptr_q];
  assign head1_o = mem_q[2'(rd_ptr_q + 2'd1)];
  assign count_o = count_q;
  assign empty_o = (count_q == 3'd0);
  assign full_o  = (count_q == 3'(FIFO_DEPTH));

endmodule

// File: rtl/rgb_sram_writer.sv
// -----------------------------------------------------------------------------
// rgb_sram_writer
// Accepts RGB pixels from the colour-space-conversion datapath, buffers them
// in a 4-entry FIFO and writes each pixel pair as three 16-bit SRAM words
// ({R0,G0}, {B0,R1}, {G1,B1}) starting at RGB_BASE_ADDR, for the VGA unit.
//
// Build option:
//   RGB_WR_CHECKSUM_EN  defined   : Checksum = running XOR of written words
//                       undefined : Checksum tied to 0, no checksum register
//
// Ports:
//   Clock            in   system clock (50 MHz)
//   Reset            in   synchronous active-high reset
//   Enable           in   frame start pulse (honoured in S_IDLE / S_DONE)
//   pixel_valid      in   upstream pixel present
//   pixel_R/G/B      in   pixel bytes
//   pixel_ready      out  pixel accepted on a cycle with pixel_valid high
//   SRAM_address     out  SRAM word address
//   SRAM_write_data  out  SRAM write word
//   SRAM_we_n        out  SRAM write enable, active-low
//   Done             out  frame fully written
//   Checksum         out  running XOR of written words (see build option)
//
// State  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | waiting for Enable after reset
// S_RUN  | frame active, waiting for a pixel pair in the FIFO
// S_WR0  | SRAM write of {R0,G0}
// S_WR1  | SRAM write of {B0,R1}
// S_WR2  | SRAM write of {G1,B1}; may pop the next pair directly
// S_DONE | frame written, Done high, waiting for Enable to re-arm
// -----------------------------------------------------------------------------
module rgb_sram_writer
  import rgb_sram_writer_pkg::*;
#(
  parameter logic [17:0] RGB_BASE_ADDR = 18'(RGB_BASE_ADDR_DEF),
  parameter logic [16:0] PIXEL_COUNT   = 17'(FRAME_PIXELS)
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  input  logic        pixel_valid,
  input  logic [7:0]  pixel_R,
  input  logic [7:0]  pixel_G,
  input  logic [7:0]  pixel_B,
  output logic        pixel_ready,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Done,
  output logic [15:0] Checksum
);

  // Address of the third word of the final pair; the address stops here.
  localparam logic [17:0] LAST_ADDR =
    18'(32'(RGB_BASE_ADDR) + (32'(PIXEL_COUNT) * 32'd3) / 32'd2 - 32'd1);

  wr_state_e   state_q, state_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_n_q, we_n_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic [16:0] acc_cnt_q, acc_cnt_d;
  rgb_pixel_t  pair0_q, pair0_d;
  rgb_pixel_t  pair1_q, pair1_d;

  logic        start;
  logic        push;
  logic        pop;
  logic        pair_avail;
  logic        in_frame_d;
  logic [2:0]  count_next;

  rgb_pixel_t  fifo_din;
  rgb_pixel_t  head0;
  rgb_pixel_t  head1;
  logic [2:0]  fifo_count;
  logic        fifo_empty;
  logic        fifo_full;

  assign fifo_din = '{r: pixel_R, g: pixel_G, b: pixel_B};

  rgb_pixel_fifo u_fifo (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (fifo_din),
    .head0_o (head0),
    .head1_o (head1),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign pair_avail = !fifo_empty && (fifo_count != 3'd1);

  // Pop a pair when waiting in S_RUN, or back-to-back from S_WR2 unless the
  // pair just written was the last one of the frame.
  assign pop = pair_avail &&
               ((state_q == S_RUN) ||
                ((state_q == S_WR2) && (addr_q != LAST_ADDR)));

  // pixel_ready is registered, so it never admits a push into a full FIFO
  // without a pop; the full term only guards against that invariant breaking.
  assign push = pixel_valid && ready_q && (!fifo_full || pop);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_n_d    = 1'b1;
    done_d    = done_q;
    pair0_d   = pair0_q;
    pair1_d   = pair1_q;
    start     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Enable) begin
          start   = 1'b1;
          state_d = S_RUN;
          addr_d  = RGB_BASE_ADDR;
          done_d  = 1'b0;
        end
      end

      S_RUN: begin
        if (pop) begin
          state_d = S_WR0;
          pair0_d = head0;
          pair1_d = head1;
          wdata_d = pack_word(head0, head1, 2'd0);
          we_n_d  = 1'b0;
        end
      end

      S_WR0: begin
        state_d = S_WR1;
        addr_d  = addr_q + 18'd1;
        wdata_d = pack_word(pair0_q, pair1_q, 2'd1);
        we_n_d  = 1'b0;
      end

      S_WR1: begin
        state_d = S_WR2;
        addr_d  = addr_q + 18'd1;
        wdata_d = pack_word(pair0_q, pair1_q, 2'd2);
        we_n_d  = 1'b0;
      end

      S_WR2: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          addr_d = addr_q + 18'd1;
          if (pop) begin
            state_d = S_WR0;
            pair0_d = head0;
            pair1_d = head1;
            wdata_d = pack_word(head0, head1, 2'd0);
            we_n_d  = 1'b0;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    acc_cnt_d = start ? 17'd0 : (acc_cnt_q + 17'(push));
  end

  // Ready looks one cycle ahead: it reflects the occupancy and accepted-pixel
  // count after this cycle's push/pop, so a registered ready never overfills
  // the FIFO or admits a pixel beyond the frame.
  always_comb begin
    in_frame_d = (state_d == S_RUN) || (state_d == S_WR0) ||
                 (state_d == S_WR1) || (state_d == S_WR2);
    count_next = 3'(fifo_count + {2'b00, push} - {1'b0, pop, 1'b0});
    ready_d    = in_frame_d && (count_next < 3'(FIFO_DEPTH)) &&
                 (acc_cnt_d < PIXEL_COUNT);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      addr_q    <= RGB_BASE_ADDR;
      wdata_q   <= 16'd0;
      we_n_q    <= 1'b1;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      acc_cnt_q <= 17'd0;
      pair0_q   <= '0;
      pair1_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_n_q    <= we_n_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      acc_cnt_q <= acc_cnt_d;
      pair0_q   <= pair0_d;
      pair1_q   <= pair1_d;
    end
  end

`ifdef RGB_WR_CHECKSUM_EN
  logic [15:0] csum_q;

  // Folds in the word currently on the SRAM bus, so it trails the write by
  // one cycle.
  always_ff @(posedge Clock) begin
    if (Reset || start) begin
      csum_q <= 16'd0;
    end else if (!we_n_q) begin
      csum_q <= csum_q ^ wdata_q;
    end
  end

  assign Checksum = csum_q;
`else
  assign Checksum = 16'd0;
`endif

  assign pixel_ready     = ready_q;
  assign SRAM_address    = addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;
  assign Done            = done_q;

endmodule
